// File: rtl/cable_sense_arbiter_pkg.sv
// Shared types and defaults for the cable-sense arbiter.
// Holds the sequencer state encoding, default timing and a one-hot helper.
// Combinational helpers only; no flow control of its own.
package cable_sense_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_MEAS   = 2'd2,
    ST_CLAMP  = 2'd3
  } state_e;

  localparam int DEF_N_PORT     = 4;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_MEAS_CYC   = 16;
  localparam int DEF_CLAMP_CYC  = 2;
  localparam int DEF_CNT_W      = 8;

  // Index of the set bit of a one-hot vector (up to 8 ports); 0 when empty.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cable_sense_arbiter_rr_arbiter.sv
// Round-robin pick: first request at or after the pointer, wrapping modulo N_PORT.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is taken.
module cable_sense_arbiter_rr_arbiter #(
  parameter int N_PORT = 4,
  parameter int PW     = 2
) (
  input  logic [N_PORT-1:0] req_i,
  input  logic [PW-1:0]     ptr_i,
  output logic [N_PORT-1:0] win_o,
  output logic              vld_o
);

  logic          found;
  logic [PW:0]   pos;

  // Scan ports starting from the pointer; the first requester wins.
  always_comb begin
    win_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N_PORT; k++) begin
      pos = {1'b0, ptr_i} + (PW+1)'(k);
      if (pos >= (PW+1)'(N_PORT)) pos = pos - (PW+1)'(N_PORT);
      if (!found && req_i[pos[PW-1:0]]) begin
        win_o[pos[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  assign vld_o = found;

endmodule

// File: rtl/cable_sense_arbiter.sv
// Shares one cable-sense path between N_PORT ports: grant, then SETTLE -> MEAS -> CLAMP.
// Latency: grant 1 cycle after request; all outputs registered; one IDLE cycle between grants.
// Backpressure: requests wait while a sequence runs; CABLE_ARB_ABORT_EN makes detect loss abort SETTLE/MEAS.
module cable_sense_arbiter
  import cable_sense_arbiter_pkg::*;
#(
  parameter int N_PORT     = DEF_N_PORT,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int MEAS_CYC   = DEF_MEAS_CYC,
  parameter int CLAMP_CYC  = DEF_CLAMP_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [N_PORT-1:0] detect_i,
  input  logic [N_PORT-1:0] flag_i,
  output logic [N_PORT-1:0] grant_o,
  output logic              en_sensor_o,
  output logic              en_acc_o,
  output logic [N_PORT-1:0] en_clamp_o,
  output logic [N_PORT-1:0] open_o,
  output logic              done_o
);

  localparam int PW = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYC - 1);
  localparam logic [CNT_W-1:0] CLAMP_LAST  = CNT_W'(CLAMP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef CABLE_ARB_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PW-1:0]     ptr_q;
  logic [N_PORT-1:0] grant_q;
  logic              en_sensor_q;
  logic              en_acc_q;
  logic [N_PORT-1:0] en_clamp_q;
  logic [N_PORT-1:0] open_q;
  logic              done_q;
  logic              lost_q;

  logic [N_PORT-1:0] req;
  logic [N_PORT-1:0] win;
  logic              win_vld;
  logic [2:0]        win_idx;
  logic [PW-1:0]     ptr_d;
  logic              lost_now;
  logic [N_PORT-1:0] open_d;

  assign req = detect_i & flag_i;

  cable_sense_arbiter_rr_arbiter #(
    .N_PORT (N_PORT),
    .PW     (PW)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win),
    .vld_o (win_vld)
  );

  assign win_idx  = onehot_to_idx(8'(win));
  assign ptr_d    = (win_idx == 3'(N_PORT - 1)) ? '0 : PW'(win_idx + 3'd1);
  // Owner has lost its cable this cycle.
  assign lost_now = |(grant_q & ~detect_i);
  // Sticky open bits survive unless the port shows a cable with no pending request.
  assign open_d   = open_q & ~(detect_i & ~flag_i);

  // Sequencer: grant, phase counting and all registered outputs.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      en_sensor_q <= 1'b0;
      en_acc_q    <= 1'b0;
      en_clamp_q  <= '0;
      open_q      <= '0;
      done_q      <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      open_q <= open_d;
      case (state_q)
        ST_IDLE: begin
          lost_q <= 1'b0;
          if (win_vld) begin
            state_q     <= ST_SETTLE;
            grant_q     <= win;
            en_sensor_q <= 1'b1;
            cnt_q       <= '0;
            ptr_q       <= ptr_d;
          end
        end
        ST_SETTLE, ST_MEAS: begin
          if (ABORT_EN && lost_now) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            en_sensor_q <= 1'b0;
            en_acc_q    <= 1'b0;
            cnt_q       <= '0;
            open_q      <= open_d | grant_q;
          end else begin
            if (lost_now) lost_q <= 1'b1;
            if (state_q == ST_SETTLE && cnt_q == SETTLE_LAST) begin
              state_q  <= ST_MEAS;
              en_acc_q <= 1'b1;
              cnt_q    <= '0;
            end else if (state_q == ST_MEAS && cnt_q == MEAS_LAST) begin
              state_q     <= ST_CLAMP;
              en_sensor_q <= 1'b0;
              en_acc_q    <= 1'b0;
              en_clamp_q  <= grant_q;
              done_q      <= (CLAMP_CYC == 1);
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          // CLAMP always runs to completion; a lost cable is reported at its end.
          if (lost_now) lost_q <= 1'b1;
          if (cnt_q == CLAMP_LAST) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            en_clamp_q <= '0;
            cnt_q      <= '0;
            if (lost_q || lost_now) open_q <= open_d | grant_q;
          end else begin
            cnt_q  <= cnt_q + CNT_ONE;
            done_q <= (cnt_q == CLAMP_LAST - CNT_ONE);
          end
        end
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign en_sensor_o = en_sensor_q;
  assign en_acc_o    = en_acc_q;
  assign en_clamp_o  = en_clamp_q;
  assign open_o      = open_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_cable_sense_arbiter.sv
module tb_cable_sense_arbiter;

  localparam int N = 4;
  localparam int S = 4;
  localparam int M = 16;
  localparam int C = 2;

`ifdef CABLE_ARB_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] detect, flag;
  logic [3:0] grant, en_clamp, open;
  logic       en_sensor, en_acc, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cable_sense_arbiter #(
    .N_PORT(N), .SETTLE_CYC(S), .MEAS_CYC(M), .CLAMP_CYC(C), .CNT_W(8)
  ) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .detect_i    (detect),
    .flag_i      (flag),
    .grant_o     (grant),
    .en_sensor_o (en_sensor),
    .en_acc_o    (en_acc),
    .en_clamp_o  (en_clamp),
    .open_o      (open),
    .done_o      (done)
  );

  // Reference model: a sequence is a position 0..S+M+C-1 within one grant.
  bit         m_busy;
  int         m_pos, m_owner, m_ptr;
  bit         m_lost;
  logic [3:0] m_open;

  function automatic void model_reset();
    m_busy = 0; m_pos = 0; m_owner = 0; m_ptr = 0; m_lost = 0; m_open = '0;
  endfunction

  function automatic void model_edge(input logic [3:0] det, input logic [3:0] flg);
    logic [3:0] nopen, rq;
    bit found, lnow;
    nopen = m_open & ~(det & ~flg);
    if (!m_busy) begin
      rq = det & flg;
      m_lost = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (!found && rq[p]) begin
          found = 1; m_owner = p;
        end
      end
      if (found) begin
        m_busy = 1; m_pos = 0; m_ptr = (m_owner + 1) % N;
      end
    end else begin
      lnow = !det[m_owner];
      if (ABORT && lnow && m_pos < S + M) begin
        m_busy = 0;
        nopen[m_owner] = 1'b1;
      end else begin
        if (lnow) m_lost = 1;
        if (m_pos == S + M + C - 1) begin
          m_busy = 0;
          if (m_lost) nopen[m_owner] = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end
    m_open = nopen;
  endfunction

  function automatic logic [14:0] model_out();
    logic [3:0] g, c;
    logic s, a, d;
    g = m_busy ? 4'(1 << m_owner) : 4'b0;
    s = m_busy && (m_pos < S + M);
    a = m_busy && (m_pos >= S) && (m_pos < S + M);
    c = (m_busy && m_pos >= S + M) ? g : 4'b0;
    d = m_busy && (m_pos == S + M + C - 1);
    return {g, s, a, c, m_open, d};
  endfunction

  task automatic check(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {grant, en_sensor, en_acc, en_clamp, open, done};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(detect, flag);
    #1;
    check(tag, model_out());
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("reset_zero", 15'd0);
    model_reset();
    #5;
    resetn = 1'b1;
  endtask

  logic [3:0] seen [4];
  logic [3:0] exp3 [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
  logic [3:0] prev;
  int nseen, ndone, nsens, nacc, nclamp;
  bit got;

  initial begin
    // 1: reset with all ports requesting, then first grant
    resetn = 1'b0; detect = 4'b1111; flag = 4'b1111;
    model_reset();
    #19;
    check("t1_reset_outputs", 15'd0);
    #1;
    resetn = 1'b1;
    tick("t1");
    check_int("t1_first_grant", int'(grant), 1);
    detect = 4'b0000; flag = 4'b0000;
    repeat (30) tick("t1_drain");

    // 2: single port 2, full sequence with flag dropping mid-way
    detect = 4'b0100; flag = 4'b0100;
    tick("t2");
    check_int("t2_grant", int'(grant), 4);
    flag = 4'b0000;
    nsens = 1; nacc = 0; nclamp = 0; ndone = 0;
    repeat (25) begin
      tick("t2_seq");
      nsens  += int'(en_sensor);
      nacc   += int'(en_acc);
      nclamp += int'(en_clamp == 4'b0100);
      ndone  += int'(done);
    end
    check_int("t2_sensor_cycles", nsens, S + M);
    check_int("t2_acc_cycles", nacc, M);
    check_int("t2_clamp_cycles", nclamp, C);
    check_int("t2_done_pulses", ndone, 1);

    // 3: round-robin with 1011 held
    do_reset();
    detect = 4'b1011; flag = 4'b1011;
    nseen = 0; prev = 4'b0;
    for (int c = 0; c < 120; c++) begin
      tick("t3");
      if (prev == 4'b0 && grant != 4'b0 && nseen < 4) begin
        seen[nseen] = grant;
        nseen++;
      end
      prev = grant;
    end
    check_int("t3_grant_count", nseen, 4);
    for (int i = 0; i < 4; i++) check_int("t3_grant_order", int'(seen[i]), int'(exp3[i]));

    // 4: late request does not preempt; port 3 follows one IDLE cycle after done
    do_reset();
    detect = 4'b0001; flag = 4'b0001;
    tick("t4");
    repeat (10) tick("t4_run");
    detect = 4'b1001; flag = 4'b1001;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick("t4_wait");
      if (done) got = 1;
    end
    check_int("t4_done_seen", int'(got), 1);
    tick("t4_idle");
    check_int("t4_idle_gap", int'(grant), 0);
    tick("t4_next");
    check_int("t4_port3_grant", int'(grant), 8);

    // 5: detect loss on port 1 at MEAS cycle 5
    do_reset();
    detect = 4'b0010; flag = 4'b0010;
    tick("t5");
    repeat (S + 5) tick("t5_run");
    detect = 4'b0000;
    tick("t5_loss");
    check_int("t5_acc_after_loss", int'(en_acc), ABORT ? 0 : 1);
    check_int("t5_grant_after_loss", int'(grant), ABORT ? 0 : 2);
    ndone = 0;
    repeat (20) begin
      tick("t5_tail");
      ndone += int'(done);
    end
    check_int("t5_done_pulses", ndone, ABORT ? 0 : 1);
    check_int("t5_open", int'(open), 2);

    // 6: asynchronous reset in MEAS, pointer restarts at 0
    detect = 4'b0100; flag = 4'b0100;
    tick("t6");
    repeat (8) tick("t6_run");
    check_int("t6_in_meas", int'(en_acc), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_reset", 15'd0);
    model_reset();
    detect = 4'b1111; flag = 4'b1111;
    #3;
    resetn = 1'b1;
    tick("t6_after");
    check_int("t6_ptr_restart", int'(grant), 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) detect = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 5) == 0) flag = 4'($urandom);
      if ($urandom_range(0, 599) == 0) do_reset();
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
